sonar_echo_timer: RTL and testbench

- Parametrised multi-channel successor to the fixed divide-by-50 microsecond counter.
- On request, fires a trigger pulse on one selected sonar channel, then measures that channel's echo high-time in microseconds.
- Reports the width with a timeout flag.
- Sits between the processor I/O write path, which supplies the start pulse and channel number, and the sensor pins.

---
 rtl/sonar_echo_timer.sv | 199 +++++++++++++++++++
 tb/tb_sonar_echo_timer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_timer.sv
// sonar_echo_timer
//   Fires a trigger pulse on one selected sonar channel, then measures that
//   channel's echo high-time in whole microseconds, with a timeout.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     measurement request (accepted only in IDLE)
//   chan      channel to measure, sampled with start
//   echo_in   raw asynchronous echo inputs, one per channel
//   trig_out  trigger outputs, at most one bit high
//   busy      high while a measurement is in progress
//   done      one-cycle completion pulse
//   timeout   set with done when the echo window expired before a fall
//   width_us  measured echo width in microseconds (all ones on timeout)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a start with a valid channel number
// TRIG      | trigger pulse high on the latched channel
// WAIT_RISE | trigger finished, waiting for a fresh echo rising edge
// MEASURE   | echo high, counting whole microsecond ticks
// DONE      | one-cycle done pulse, result registers are valid
module sonar_echo_timer #(
  parameter int CLK_PER_US = 50,
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 8,
  parameter int CH_BITS    = 3,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CH_BITS-1:0]  chan,
  input  logic [CHANNELS-1:0] echo_in,
  output logic [CHANNELS-1:0] trig_out,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [WIDTH-1:0]    width_us
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam int TRIG_CYC = TRIG_US * CLK_PER_US;
  localparam int TRIG_W   = $clog2(TRIG_CYC);
  localparam int PRESC_W  = $clog2(CLK_PER_US);

  localparam logic [CH_BITS:0]    CH_LIMIT   = (CH_BITS+1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] CH_ONE     = CHANNELS'(1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
  localparam logic [TRIG_W-1:0]   TRIG_LOAD  = TRIG_W'(TRIG_CYC - 1);
  localparam logic [WIDTH-1:0]    US_LAST    = WIDTH'(TIMEOUT_US - 1);

  state_t               state;
  logic [CH_BITS-1:0]   chan_latched;
  logic [TRIG_W-1:0]    trig_cnt;
  logic [PRESC_W-1:0]   presc;
  logic [WIDTH-1:0]     us_cnt;
  logic [WIDTH-1:0]     width_cnt;

  logic [CHANNELS-1:0]  echo_meta;
  logic [CHANNELS-1:0]  echo_sync;
  logic [CHANNELS-1:0]  echo_prev;

  logic                 tick;
  logic                 sel_sync;
  logic                 sel_prev;
  logic                 rise;
  logic                 fall;
  logic                 us_expire;
  logic [WIDTH-1:0]     width_inc;
  logic [WIDTH-1:0]     width_next;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
      echo_prev <= '0;
    end else begin
      echo_meta <= echo_in;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  always_comb begin
    tick      = (presc == PRESC_LAST);
    sel_sync  = echo_sync[chan_latched];
    sel_prev  = echo_prev[chan_latched];
    rise      = sel_sync & ~sel_prev;
    fall      = ~sel_sync & sel_prev;
    // Timeout fires on the tick that brings the us counter to TIMEOUT_US.
    us_expire = tick && (us_cnt == US_LAST);
    // Saturating width count; includes a tick landing on the fall cycle.
    width_inc  = (width_cnt == '1) ? width_cnt : width_cnt + 1'b1;
    width_next = tick ? width_inc : width_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      chan_latched <= '0;
      trig_cnt     <= '0;
      presc        <= '0;
      us_cnt       <= '0;
      width_cnt    <= '0;
      trig_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      width_us     <= '0;
    end else begin
      done  <= 1'b0;
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        S_IDLE: begin
          if (start && ({1'b0, chan} < CH_LIMIT)) begin
            chan_latched <= chan;
            timeout      <= 1'b0;
            busy         <= 1'b1;
            trig_out     <= CH_ONE << chan;
            trig_cnt     <= TRIG_LOAD;
            presc        <= '0;
            state        <= S_TRIG;
          end
        end

        S_TRIG: begin
          if (trig_cnt == '0) begin
            trig_out <= '0;
            us_cnt   <= '0;
            presc    <= '0;
            state    <= S_WAIT_RISE;
          end else begin
            trig_cnt <= trig_cnt - 1'b1;
          end
        end

        S_WAIT_RISE: begin
          if (us_expire) begin
            width_us <= '1;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            presc    <= '0;
            state    <= S_DONE;
          end else begin
            if (tick) us_cnt <= us_cnt + 1'b1;
            if (rise) begin
              width_cnt <= '0;
              presc     <= '0;
              state     <= S_MEASURE;
            end
          end
        end

        S_MEASURE: begin
          if (us_expire) begin
            width_us <= '1;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            presc    <= '0;
            state    <= S_DONE;
          end else if (fall) begin
            width_us <= width_next;
            busy     <= 1'b0;
            done     <= 1'b1;
            presc    <= '0;
            state    <= S_DONE;
          end else begin
            if (tick) us_cnt <= us_cnt + 1'b1;
            width_cnt <= width_next;
          end
        end

        S_DONE: begin
          presc <= '0;
          state <= S_IDLE;
        end

        default: begin
          presc <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_echo_timer.sv
// tb_sonar_echo_timer
//   Self-checking bench for sonar_echo_timer: a table of directed
//   measurements, hand-written corner sequences, and randomised runs
//   compared against a microsecond-arithmetic reference model.
module tb_sonar_echo_timer;

  localparam int CLK_PER_US = 4;
  localparam int TRIG_US    = 2;
  localparam int TIMEOUT_US = 100;
  localparam int CHANNELS   = 4;
  localparam int CH_BITS    = 2;
  localparam int WIDTH      = 16;
  localparam int TRIG_CYC   = TRIG_US * CLK_PER_US;
  localparam int TO_CYC     = TRIG_CYC + TIMEOUT_US * CLK_PER_US;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [CH_BITS-1:0]  chan;
  logic [CHANNELS-1:0] echo_in;
  logic [CHANNELS-1:0] trig_out;
  logic                busy;
  logic                done;
  logic                timeout;
  logic [WIDTH-1:0]    width_us;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  typedef struct {
    int               ch;
    int               dly;
    int               high;
    bit               pre_high;
    bit               noise;
    bit               mid_start;
    logic [WIDTH-1:0] exp_w;
    bit               exp_to;
  } vec_t;

  vec_t vecs[8];

  sonar_echo_timer #(
    .CLK_PER_US (CLK_PER_US),
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .CH_BITS    (CH_BITS),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .chan     (chan),
    .echo_in  (echo_in),
    .trig_out (trig_out),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .width_us (width_us)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: echo high for N cycles spans floor(N / CLK_PER_US) whole us.
  function automatic logic [WIDTH-1:0] model_width(input int high_cycles);
    int w;
    w = high_cycles / CLK_PER_US;
    if (w > 2**WIDTH - 1) w = 2**WIDTH - 1;
    return WIDTH'(w);
  endfunction

  task automatic run_meas(input vec_t v,
                          output logic [WIDTH-1:0] w, output logic to,
                          output int trig_n, output int lat, output bit got_done,
                          output int glitch, output logic busy0);
    logic [CHANNELS-1:0] onehot;
    logic                sel;
    int                  c;
    onehot = '0;
    onehot[v.ch] = 1'b1;
    glitch = 0; trig_n = 0; got_done = 0; c = 0;
    echo_in = '0;
    if (v.pre_high) begin
      echo_in[v.ch] = 1'b1;
      repeat (4) step();
    end
    start = 1'b1;
    chan  = CH_BITS'(v.ch);
    step();
    start = 1'b0;
    busy0 = busy;
    while (trig_out != '0 && trig_n < 4 * TRIG_CYC) begin
      if (trig_out !== onehot) glitch++;
      if (v.mid_start && trig_n == 2) begin
        start = 1'b1;
        chan  = CH_BITS'((v.ch + 1) % CHANNELS);
      end
      step();
      start = 1'b0;
      trig_n++;
    end
    while (!got_done && c < 1000) begin
      sel = v.pre_high || (v.high > 0 && c >= v.dly && c < v.dly + v.high);
      for (int i = 0; i < CHANNELS; i++)
        echo_in[i] = (i == v.ch) ? sel : (v.noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (v.mid_start && c == v.dly + 2) begin
        start = 1'b1;
        chan  = CH_BITS'((v.ch + 1) % CHANNELS);
      end
      step();
      start = 1'b0;
      c++;
      if (trig_out != '0) glitch++;
      if (done === 1'b1) got_done = 1'b1;
    end
    lat = trig_n + c;
    w   = width_us;
    to  = timeout;
    echo_in = '0;
  endtask

  task automatic check_run(input string tag, input vec_t v);
    logic [WIDTH-1:0] w;
    logic             to;
    int               trig_n, lat, glitch, dc0;
    bit               got_done;
    logic             busy0;
    dc0 = done_count;
    run_meas(v, w, to, trig_n, lat, got_done, glitch, busy0);
    check({tag, " busy_after_start"}, busy0, 1);
    check({tag, " trig_cycles"}, trig_n, TRIG_CYC);
    check({tag, " trig_glitch"}, glitch, 0);
    check({tag, " done_seen"}, got_done, 1);
    check({tag, " width_us"}, w, v.exp_w);
    check({tag, " timeout"}, to, v.exp_to);
    if (v.exp_to)
      check({tag, " timeout_latency_in_window"}, (lat >= TO_CYC - 1 && lat <= TO_CYC + 1), 1);
    step();
    step();
    check({tag, " done_pulses"}, done_count - dc0, 1);
    check({tag, " trig_idle"}, trig_out, 0);
  endtask

  initial begin : main
    vec_t v;
    int   n;
    int   dc;

    //          ch dly high pre noise mid  width   to
    vecs[0] = '{2, 20,  40, 0,  0,    0,   16'd10, 0};
    vecs[1] = '{1,  0,   0, 0,  0,    0, 16'hFFFF, 1};
    vecs[2] = '{0,  0,   0, 1,  0,    0, 16'hFFFF, 1};
    vecs[3] = '{0, 10,  37, 0,  1,    0,   16'd9,  0};
    vecs[4] = '{0,  5,  20, 0,  0,    1,   16'd5,  0};
    vecs[5] = '{3,  0,   3, 0,  0,    0,   16'd0,  0};
    vecs[6] = '{2,  1,   4, 0,  1,    1,   16'd1,  0};
    vecs[7] = '{1, 30, 200, 0,  0,    0,   16'd50, 0};

    reset = 1'b1; start = 1'b0; chan = '0; echo_in = '0;
    repeat (3) step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset timeout", timeout, 0);
    check("reset width_us", width_us, 0);
    check("reset trig_out", trig_out, 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) check_run($sformatf("vec%0d", i), vecs[i]);

    // Start in the DONE cycle is ignored, the next cycle's start is taken.
    v = '{2, 3, 12, 0, 0, 0, 16'd3, 0};
    begin
      logic [WIDTH-1:0] w; logic to; int tn, lat, gl; bit gd; logic b0;
      run_meas(v, w, to, tn, lat, gd, gl, b0);
      check("pre_done width_us", w, 3);
      check("pre_done done_seen", gd, 1);
    end
    start = 1'b1; chan = 2'd1;
    step();
    start = 1'b0;
    check("done_cycle_start busy", busy, 0);
    check("done_cycle_start trig_out", trig_out, 0);
    start = 1'b1; chan = 2'd1;
    step();
    start = 1'b0;
    check("after_done_start busy", busy, 1);
    check("after_done_start trig_out", trig_out, 4'b0010);

    // Reset in MEASURE aborts without ever pulsing done.
    n = 0;
    while (trig_out != '0 && n < 4 * TRIG_CYC) begin
      step();
      n++;
    end
    echo_in[1] = 1'b1;
    repeat (12) step();
    dc = done_count;
    reset = 1'b1;
    step();
    reset = 1'b0;
    echo_in = '0;
    check("mid_reset busy", busy, 0);
    check("mid_reset trig_out", trig_out, 0);
    check("mid_reset width_us", width_us, 0);
    check("mid_reset done", done, 0);
    repeat (500) step();
    check("mid_reset no_done", done_count - dc, 0);
    check_run("post_reset", '{1, 2, 20, 0, 0, 0, 16'd5, 0});

    // Randomised runs against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      v.ch        = $urandom_range(0, CHANNELS - 1);
      v.dly       = $urandom_range(0, 60);
      v.high      = $urandom_range(1, 160);
      v.pre_high  = 1'b0;
      v.noise     = 1'($urandom_range(0, 1));
      v.mid_start = 1'($urandom_range(0, 1));
      v.exp_w     = model_width(v.high);
      v.exp_to    = 1'b0;
      check_run($sformatf("rand%0d", r), v);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
